rf_frame_ctrl: RTL and testbench



---
 rtl/rf_frame_pkg.sv | 21 ++
 rtl/rf_frame_check.sv | 58 +++++
 rtl/rf_frame_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_rf_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_frame_pkg.sv
// Shared types and constants for the RF frame controller.
// States, error codes, CRC-8 polynomial and byte width.
package rf_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LINE  = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CHECK = 2'd3;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int         BYTE_W    = 8;

endpackage

// File: rtl/rf_frame_check.sv
// Frame check accumulator: byte XOR, or CRC-8 under RF_FRAME_CRC8_EN.
// Ports: clk2x, rst_n, clear, bit_in, bit_en -> check[7:0].
module rf_frame_check
  import rf_frame_pkg::*;
(
  input  logic              clk2x,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [BYTE_W-1:0] check
);

`ifdef RF_FRAME_CRC8_EN
  logic [BYTE_W-1:0] crc_q;
  logic              fb;

  assign fb    = crc_q[BYTE_W-1] ^ bit_in;
  assign check = crc_q;

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (bit_en) begin
      crc_q <= {crc_q[BYTE_W-2:0], 1'b0}
             ^ (fb ? CRC8_POLY : 8'h00);
    end
  end
`else
  logic [BYTE_W-1:0] sh_q;
  logic [BYTE_W-1:0] acc_q;
  logic [2:0]        cnt_q;
  logic [BYTE_W-1:0] nb;

  assign nb    = {sh_q[BYTE_W-2:0], bit_in};
  assign check = acc_q;

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (bit_en) begin
      sh_q  <= nb;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7)
        acc_q <= acc_q ^ nb;
    end
  end
`endif

endmodule

// File: rtl/rf_frame_ctrl.sv
// Frame controller: sync hunt, length, payload, check over decoded bits.
// Ports: clk2x/rst_n, start/abort, decoder bit side, byte valid/ready side,
// busy/frame_done/frame_err/err_code status. Build option RF_FRAME_CRC8_EN.
module rf_frame_ctrl
  import rf_frame_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'h2DD4,
  parameter int unsigned       MAX_LEN   = 32,
  parameter int unsigned       ERR_LIMIT = 4,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic       clk2x,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dec_enable,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       bit_error,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int CW = $clog2(SYNC_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SYNC_N = CW'(SYNC_W);
  localparam logic [TW-1:0] TLIM   = TW'(TIMEOUT);
  localparam logic [3:0]    ELIM   = 4'(ERR_LIMIT);
  localparam logic [7:0]    MLEN   = 8'(MAX_LEN);

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sync_q;
  logic [CW-1:0]     scnt_q;
  logic [7:0]        sh_q;
  logic [2:0]        bcnt_q;
  logic [7:0]        len_q, pcnt_q;
  logic [3:0]        erun_q;
  logic [TW-1:0]     idle_q;
  logic [7:0]        chk;
  logic [7:0]        nbyte;
  logic              good, bad, in_frame;
  logic              byte_done, sync_hit, arm;
  logic              fin, fin_err, load;
  logic [1:0]        fin_code;

  assign good     = bit_valid & ~bit_error;
  assign bad      = bit_valid & bit_error;
  assign in_frame = state_q inside {S_LEN, S_PAYLOAD, S_CHECK};
  assign nbyte    = {sh_q[6:0], bit_data};
  assign byte_done = in_frame & good & (bcnt_q == 3'd7);
  assign sync_hit = (state_q == S_HUNT) && (scnt_q == SYNC_N)
                    && (sync_q == SYNC_WORD);
  assign arm      = (state_q == S_IDLE) & start & ~abort;
  assign fin_err  = fin_code != ERR_NONE;

  rf_frame_check u_check (
    .clk2x  (clk2x),
    .rst_n  (rst_n),
    .clear  (arm),
    .bit_in (bit_data),
    .bit_en (good & ~abort
             & (state_q inside {S_LEN, S_PAYLOAD})),
    .check  (chk)
  );

  // Terminating events; line faults outrank a byte completion.
  always_comb begin
    fin      = 1'b0;
    fin_code = ERR_NONE;
    load     = 1'b0;
    if (in_frame) begin
      if (bad && (erun_q + 4'd1 == ELIM)) begin
        fin      = 1'b1;
        fin_code = ERR_LINE;
      end else if (!bit_valid && (idle_q + TW'(1) == TLIM)) begin
        fin      = 1'b1;
        fin_code = ERR_LINE;
      end else if (byte_done) begin
        unique case (state_q)
          S_LEN: begin
            if (nbyte == 8'd0 || nbyte > MLEN) begin
              fin      = 1'b1;
              fin_code = ERR_LEN;
            end
          end
          S_PAYLOAD: begin
            if (byte_valid && !byte_ready) begin
              fin      = 1'b1;
              fin_code = ERR_LINE;
            end else begin
              load = 1'b1;
            end
          end
          S_CHECK: begin
            fin      = 1'b1;
            fin_code = (nbyte == chk) ? ERR_NONE : ERR_CHECK;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort || fin) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (start) state_d = S_HUNT;
        S_HUNT:    if (sync_hit) state_d = S_LEN;
        S_LEN:     if (byte_done) state_d = S_PAYLOAD;
        S_PAYLOAD: if (load && (pcnt_q + 8'd1 == len_q))
                     state_d = S_CHECK;
        default:   ;
      endcase
    end
  end

  always_comb begin
    dec_enable = state_q != S_IDLE;
    busy       = state_q != S_IDLE;
  end

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      scnt_q     <= '0;
      sh_q       <= '0;
      bcnt_q     <= '0;
      len_q      <= '0;
      pcnt_q     <= '0;
      erun_q     <= '0;
      idle_q     <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (byte_valid && byte_ready)
        byte_valid <= 1'b0;
      if (abort) begin
        byte_valid <= 1'b0;
      end else if (arm) begin
        err_code <= ERR_NONE;
        sync_q   <= '0;
        scnt_q   <= '0;
        sh_q     <= '0;
        bcnt_q   <= '0;
        len_q    <= '0;
        pcnt_q   <= '0;
        erun_q   <= '0;
        idle_q   <= '0;
      end else begin
        if (state_q == S_HUNT) begin
          sh_q   <= '0;
          bcnt_q <= '0;
          erun_q <= '0;
          idle_q <= '0;
          if (bad) begin
            scnt_q <= '0;
          end else if (good) begin
            sync_q <= {sync_q[SYNC_W-2:0], bit_data};
            if (scnt_q != SYNC_N)
              scnt_q <= scnt_q + CW'(1);
          end
        end
        if (in_frame) begin
          if (good) begin
            sh_q   <= nbyte;
            bcnt_q <= bcnt_q + 3'd1;
            erun_q <= '0;
          end else if (bad) begin
            erun_q <= erun_q + 4'd1;
          end
          idle_q <= bit_valid ? '0 : idle_q + TW'(1);
        end
        if (state_q == S_LEN && byte_done) begin
          len_q  <= nbyte;
          pcnt_q <= '0;
        end
        if (load) begin
          byte_data  <= nbyte;
          byte_valid <= 1'b1;
          pcnt_q     <= pcnt_q + 8'd1;
        end
        if (fin) begin
          frame_done <= 1'b1;
          frame_err  <= fin_err;
          err_code   <= fin_code;
          if (fin_err)
            byte_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_frame_ctrl.sv
// Directed bench for rf_frame_ctrl (default XOR check build).
// Drives bits on negedge, observes handshakes and pulses on posedge.
module tb_rf_frame_ctrl;
  import rf_frame_pkg::*;

  logic       clk2x = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dec_enable;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_error = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int done_n = 0;
  int ferr_n = 0;
  int bv_n   = 0;
  int q0, d0, e0, b0;

  rf_frame_ctrl dut (
    .clk2x      (clk2x),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .dec_enable (dec_enable),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_error  (bit_error),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk2x = ~clk2x;

  always @(posedge clk2x) begin
    if (byte_valid && byte_ready) rx_q.push_back(byte_data);
    if (frame_done) done_n++;
    if (frame_err)  ferr_n++;
    if (byte_valid) bv_n++;
  end

  task automatic chk_eq(string tag, logic [31:0] got,
                        logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    q0 = rx_q.size();
    d0 = done_n;
    e0 = ferr_n;
    b0 = bv_n;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk2x);
  endtask

  task automatic send_bit(logic b, logic e);
    @(negedge clk2x);
    bit_valid = 1'b1;
    bit_data  = b;
    bit_error = e;
    @(negedge clk2x);
    bit_valid = 1'b0;
    bit_error = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic arm();
    @(negedge clk2x);
    start = 1'b1;
    @(negedge clk2x);
    start = 1'b0;
  endtask

  task automatic sync_hdr();
    arm();
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h2D);
    send_byte(8'hD4);
  endtask

  task automatic do_abort();
    @(negedge clk2x);
    abort = 1'b1;
    @(negedge clk2x);
    abort = 1'b0;
  endtask

  initial begin
    idle(3);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_dec_en", dec_enable, 0);
    chk_eq("rst_bvalid", byte_valid, 0);
    chk_eq("rst_errcode", err_code, 0);
    chk_eq("rst_done", frame_done, 0);
    rst_n = 1'b1;
    idle(2);

    // good frame
    mark();
    sync_hdr();
    chk_eq("g_busy", busy, 1);
    chk_eq("g_dec_en", dec_enable, 1);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h03);
    idle(3);
    chk_eq("g_nbytes", rx_q.size() - q0, 3);
    chk_eq("g_b0", rx_q[q0], 8'h11);
    chk_eq("g_b1", rx_q[q0+1], 8'h22);
    chk_eq("g_b2", rx_q[q0+2], 8'h33);
    chk_eq("g_done", done_n - d0, 1);
    chk_eq("g_ferr", ferr_n - e0, 0);
    chk_eq("g_code", err_code, ERR_NONE);
    chk_eq("g_busy_end", busy, 0);

    // bad check byte
    mark();
    sync_hdr();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h04);
    idle(3);
    chk_eq("c_nbytes", rx_q.size() - q0, 3);
    chk_eq("c_done", done_n - d0, 1);
    chk_eq("c_ferr", ferr_n - e0, 1);
    chk_eq("c_code", err_code, ERR_CHECK);
    idle(10);
    chk_eq("c_code_held", err_code, ERR_CHECK);

    // length zero
    mark();
    sync_hdr();
    send_byte(8'h00);
    idle(3);
    chk_eq("l0_ferr", ferr_n - e0, 1);
    chk_eq("l0_code", err_code, ERR_LEN);
    chk_eq("l0_bv", bv_n - b0, 0);
    chk_eq("l0_busy", busy, 0);

    // length one past max
    mark();
    sync_hdr();
    send_byte(8'h21);
    idle(3);
    chk_eq("l21_ferr", ferr_n - e0, 1);
    chk_eq("l21_code", err_code, ERR_LEN);
    chk_eq("l21_bv", bv_n - b0, 0);

    // four consecutive bit errors
    mark();
    sync_hdr();
    send_byte(8'h02);
    repeat (4) send_bit(1'b0, 1'b1);
    idle(3);
    chk_eq("e4_ferr", ferr_n - e0, 1);
    chk_eq("e4_code", err_code, ERR_LINE);
    chk_eq("e4_busy", busy, 0);

    // three errors then good bits: frame survives
    mark();
    sync_hdr();
    send_byte(8'h02);
    repeat (3) send_bit(1'b1, 1'b1);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hFD);
    idle(3);
    chk_eq("e3_done", done_n - d0, 1);
    chk_eq("e3_ferr", ferr_n - e0, 0);
    chk_eq("e3_nbytes", rx_q.size() - q0, 2);
    chk_eq("e3_b0", rx_q[q0], 8'h5A);
    chk_eq("e3_b1", rx_q[q0+1], 8'hA5);

    // overrun with consumer stalled
    mark();
    byte_ready = 1'b0;
    sync_hdr();
    send_byte(8'h02);
    send_byte(8'h11);
    chk_eq("o_bv_first", byte_valid, 1);
    send_byte(8'h22);
    idle(3);
    chk_eq("o_ferr", ferr_n - e0, 1);
    chk_eq("o_code", err_code, ERR_LINE);
    chk_eq("o_bv_clr", byte_valid, 0);
    byte_ready = 1'b1;
    idle(2);
    chk_eq("o_nbytes", rx_q.size() - q0, 0);

    // abort together with start mid-payload
    mark();
    sync_hdr();
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk2x);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk2x);
    abort = 1'b0;
    start = 1'b0;
    chk_eq("a_busy", busy, 0);
    chk_eq("a_dec_en", dec_enable, 0);
    chk_eq("a_bv", byte_valid, 0);
    idle(5);
    chk_eq("a_done", done_n - d0, 0);
    chk_eq("a_code", err_code, ERR_NONE);
    chk_eq("a_idle", busy, 0);

    // HUNT ignores the timeout
    mark();
    arm();
    idle(2000);
    chk_eq("h_busy", busy, 1);
    chk_eq("h_done", done_n - d0, 0);
    do_abort();
    chk_eq("h_abort", busy, 0);

    // PAYLOAD timeout at exactly TIMEOUT idle cycles
    mark();
    sync_hdr();
    send_byte(8'h02);
    send_byte(8'h11);
    idle(1022);
    chk_eq("t_busy_1022", busy, 1);
    idle(3);
    chk_eq("t_busy_end", busy, 0);
    chk_eq("t_done", done_n - d0, 1);
    chk_eq("t_ferr", ferr_n - e0, 1);
    chk_eq("t_code", err_code, ERR_LINE);

    // async reset mid-frame
    sync_hdr();
    send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("r_busy", busy, 0);
    chk_eq("r_dec_en", dec_enable, 0);
    rst_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
